stream_rr_arb: RTL and testbench

- Packet-aware round-robin arbiter that shares one valid/ready output stream among N valid/ready requesters.
- A grant is held from the first beat of a packet until its last beat transfers, so packets never interleave.
- The output is driven by a single-entry registered stage with full-throughput handshake.
- Sits in front of any shared stream consumer in the AXI examples, e.g. a common write-data channel or a shared FIFO.

---
 rtl/stream_pkg.sv | 26 ++
 rtl/stream_rr_pick.sv | 33 +++
 rtl/stream_rr_arb.sv | 121 ++++++++++++
 tb/tb_stream_rr_arb.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared stream-arbitration types and a reusable rotate-priority search.
package stream_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  // Widest request vector accepted by rr_search.
  localparam int RR_MAX_N = 32;

  // Index of the first set request at or after ptr, wrapping mod n.
  // Returns ptr when no request is set, so callers gate on |req.
  function automatic int rr_search(input logic [RR_MAX_N-1:0] req,
                                   input int n, input int ptr);
    int idx;
    int res;
    res = ptr;
    for (int i = RR_MAX_N - 1; i >= 0; i--) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (req[idx]) res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_rr_pick.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           any,
  output logic [IDW-1:0] win
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [IDW-1:0] off;
  logic [IDW:0]   sum;

  // Doubling the vector turns the wrap-around rotate into a plain shift.
  assign req_dbl = {req, req};
  assign req_rot = N'(req_dbl >> ptr);
  assign any     = |req;

  // Priority-encode the rotated vector, then undo the rotation mod N.
  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) off = IDW'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (int'(sum) >= N) win = IDW'(int'(sum) - N);
    else                win = sum[IDW-1:0];
  end

endmodule

// File: rtl/stream_rr_arb.sv
// Packet-aware round-robin stream arbiter with a registered output stage.
module stream_rr_arb
  import stream_pkg::*;
#(
  parameter int  N     = 4,
  parameter int  WIDTH = 32,
  localparam int IDW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       i_vld,
  output logic [N-1:0]       o_rdy,
  input  logic [N*WIDTH-1:0] i_data,
  input  logic [N-1:0]       i_last,
  output logic               o_vld,
  input  logic               i_rdy,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_last,
  output logic [IDW-1:0]     o_id
);

  localparam logic [IDW-1:0] LAST_IDX = IDW'(N - 1);

  arb_state_t       state, state_nxt;
  logic [IDW-1:0]   ptr, ptr_nxt, gnt, gnt_nxt, win;
  logic             any_req, can_acc, in_xfer, sel_vld, sel_last;
  logic [WIDTH-1:0] sel_data;
  logic             vld_p1, last_p1;
  logic [WIDTH-1:0] data_p1;
  logic [IDW-1:0]   id_p1;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req (i_vld),
    .ptr (ptr),
    .any (any_req),
    .win (win)
  );

  assign can_acc = !vld_p1 || i_rdy;
  assign in_xfer = (state == ARB_LOCKED) && sel_vld && can_acc;

  // Steer the granted requester's beat onto the stage input.
  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt == IDW'(k)) begin
        sel_vld  = i_vld[k];
        sel_last = i_last[k];
        sel_data = i_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Ready only to the granted requester; never a function of i_vld.
  always_comb begin
    o_rdy = '0;
    for (int k = 0; k < N; k++) begin
      o_rdy[k] = !rst && (state == ARB_LOCKED) && (gnt == IDW'(k)) && can_acc;
    end
  end

  // Next state: arbitrate while idle, release the lock after the last beat.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    case (state)
      ARB_IDLE: begin
        if (any_req) begin
          gnt_nxt   = win;
          state_nxt = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (in_xfer && sel_last) begin
          ptr_nxt   = (gnt == LAST_IDX) ? '0 : gnt + 1'b1;
          state_nxt = ARB_IDLE;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // Arbitration state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      ptr   <= '0;
      gnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
    end
  end

  // Output stage p1: load on input transfer, drain when downstream takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      id_p1   <= '0;
    end else if (in_xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data;
      last_p1 <= sel_last;
      id_p1   <= gnt;
    end else if (i_rdy) begin
      vld_p1  <= 1'b0;
    end
  end

  assign o_vld  = vld_p1;
  assign o_data = data_p1;
  assign o_last = last_p1;
  assign o_id   = id_p1;

endmodule

// File: tb/tb_stream_rr_arb.sv
// Directed testbench for stream_rr_arb (N=4, WIDTH=32).
module tb_stream_rr_arb;
  localparam int N = 4;
  localparam int WIDTH = 32;
  localparam int IDW = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N-1:0]       i_vld, o_rdy, i_last;
  logic [N*WIDTH-1:0] i_data;
  logic               o_vld, i_rdy, o_last;
  logic [WIDTH-1:0]   o_data;
  logic [IDW-1:0]     o_id;

  always #5 clk = ~clk;

  stream_rr_arb #(.N(N), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .i_vld(i_vld), .o_rdy(o_rdy), .i_data(i_data),
    .i_last(i_last), .o_vld(o_vld), .i_rdy(i_rdy), .o_data(o_data),
    .o_last(o_last), .o_id(o_id)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Requester model: pkts packets of plen beats, data = base + pkt*16 + beat.
  int pkts[N], plen[N], beat[N], sent[N], in_cnt[N];
  logic [WIDTH-1:0] base[N];
  bit pause[N];

  // Per-cycle samples and the log of output transfers.
  logic [N-1:0] s_ordy, s_ixfer;
  logic s_ovld, s_olast, s_oxfer;
  logic [WIDTH-1:0] s_odata;
  logic [IDW-1:0] s_oid;
  logic [WIDTH-1:0] log_data[$];
  logic [IDW-1:0] log_id[$];
  logic log_last[$];
  int log_cyc[$];

  task automatic drive_inputs();
    for (int k = 0; k < N; k++) begin
      i_vld[k] = (pkts[k] > 0) && !pause[k];
      i_last[k] = (beat[k] == plen[k] - 1);
      i_data[k*WIDTH +: WIDTH] = base[k] + WIDTH'(sent[k] * 16 + beat[k]);
    end
  endtask

  task automatic load(input int k, input int np, input int len, input logic [WIDTH-1:0] b);
    pkts[k] = np; plen[k] = len; base[k] = b; sent[k] = 0; beat[k] = 0; pause[k] = 0;
  endtask

  task automatic clear_logs();
    log_data.delete(); log_id.delete(); log_last.delete(); log_cyc.delete();
  endtask

  // One clock: sample at negedge, advance the requester model after posedge.
  task automatic step();
    @(negedge clk);
    s_ordy = o_rdy; s_ovld = o_vld; s_odata = o_data; s_olast = o_last; s_oid = o_id;
    s_oxfer = o_vld && i_rdy && !rst;
    s_ixfer = i_vld & o_rdy;
    if (s_oxfer) begin
      log_data.push_back(o_data); log_id.push_back(o_id);
      log_last.push_back(o_last); log_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) begin
      if (s_ixfer[k]) begin
        in_cnt[k]++;
        if (beat[k] == plen[k] - 1) begin
          beat[k] = 0; sent[k]++; pkts[k]--;
        end else begin
          beat[k]++;
        end
      end
    end
    drive_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1; i_rdy = 1'b1;
    for (int k = 0; k < N; k++) begin load(k, 0, 1, '0); in_cnt[k] = 0; end
    drive_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (s_ordy !== 4'b0000) begin failures++; $display("FAIL reset_ordy: got %b expected 0000", s_ordy); end
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (s_ovld !== 1'b0) begin failures++; $display("FAIL idle_ovld cycle %0d: got %b expected 0", i, s_ovld); end
      checks++; if (s_ordy !== 4'b0000) begin failures++; $display("FAIL idle_ordy cycle %0d: got %b expected 0000", i, s_ordy); end
      checks++; if (s_oid !== 2'd0) begin failures++; $display("FAIL idle_oid cycle %0d: got %0d expected 0", i, s_oid); end
    end
    checks++; if (s_odata !== 32'h0 || s_olast !== 1'b0) begin failures++; $display("FAIL idle_odata: got %h/%b expected 0/0", s_odata, s_olast); end
  endtask

  task automatic test_single_packet();
    int c0;
    clear_logs();
    load(2, 1, 3, 32'hA0);
    drive_inputs();
    c0 = cyc;
    step();
    checks++; if (s_ordy !== 4'b0000) begin failures++; $display("FAIL pkt_bubble_ordy: got %b expected 0000", s_ordy); end
    step();
    checks++; if (s_ordy !== 4'b0100) begin failures++; $display("FAIL pkt_grant_ordy: got %b expected 0100", s_ordy); end
    for (int t = 0; t < 20 && log_data.size() < 3; t++) step();
    checks++;
    if (log_data.size() < 3) begin
      failures++; $display("FAIL pkt_timeout: got %0d beats expected 3", log_data.size());
    end else begin
      checks++; if (log_cyc[0] != c0 + 2) begin failures++; $display("FAIL pkt_latency: got cycle %0d expected %0d", log_cyc[0], c0 + 2); end
      for (int i = 0; i < 3; i++) begin
        checks++; if (log_data[i] !== 32'hA0 + 32'(i)) begin failures++; $display("FAIL pkt_data[%0d]: got %h expected %h", i, log_data[i], 32'hA0 + 32'(i)); end
        checks++; if (log_id[i] !== 2'd2) begin failures++; $display("FAIL pkt_id[%0d]: got %0d expected 2", i, log_id[i]); end
        checks++; if (log_last[i] !== (i == 2)) begin failures++; $display("FAIL pkt_last[%0d]: got %b expected %b", i, log_last[i], i == 2); end
        checks++; if (log_cyc[i] != log_cyc[0] + i) begin failures++; $display("FAIL pkt_consec[%0d]: got cycle %0d expected %0d", i, log_cyc[i], log_cyc[0] + i); end
      end
    end
    // Pointer now at 3: requester 3 must beat requester 1.
    clear_logs();
    load(1, 1, 1, 32'h100);
    load(3, 1, 1, 32'h300);
    drive_inputs();
    for (int t = 0; t < 20 && log_data.size() < 2; t++) step();
    checks++;
    if (log_data.size() < 2) begin
      failures++; $display("FAIL ptr_timeout: got %0d beats expected 2", log_data.size());
    end else begin
      checks++; if (log_id[0] !== 2'd3 || log_id[1] !== 2'd1) begin failures++; $display("FAIL ptr_order: got %0d,%0d expected 3,1", log_id[0], log_id[1]); end
      checks++; if (log_data[0] !== 32'h300 || log_data[1] !== 32'h100) begin failures++; $display("FAIL ptr_data: got %h,%h expected 300,100", log_data[0], log_data[1]); end
    end
  endtask

  task automatic test_round_robin();
    int k, e;
    repeat (3) step();
    clear_logs();
    for (int j = 0; j < N; j++) load(j, 2, 2, WIDTH'(j * 256));
    drive_inputs();
    for (int t = 0; t < 100 && log_data.size() < 16; t++) step();
    checks++;
    if (log_data.size() < 16) begin
      failures++; $display("FAIL rr_timeout: got %0d beats expected 16", log_data.size());
    end else begin
      // Pointer starts at 2 after the previous test (last grant was 1).
      for (int i = 0; i < 16; i++) begin
        k = (2 + i / 2) % N;
        e = k * 256 + (i / 8) * 16 + (i % 2);
        checks++; if (log_id[i] !== IDW'(k)) begin failures++; $display("FAIL rr_id[%0d]: got %0d expected %0d", i, log_id[i], k); end
        checks++; if (log_data[i] !== WIDTH'(e)) begin failures++; $display("FAIL rr_data[%0d]: got %h expected %h", i, log_data[i], e); end
        checks++; if (log_last[i] !== (i % 2 == 1)) begin failures++; $display("FAIL rr_last[%0d]: got %b expected %b", i, log_last[i], i % 2 == 1); end
        if (i % 2 == 1) begin
          checks++; if (log_cyc[i] != log_cyc[i-1] + 1) begin failures++; $display("FAIL rr_beat_gap[%0d]: got %0d expected %0d", i, log_cyc[i], log_cyc[i-1] + 1); end
        end else if (i > 0) begin
          checks++; if (log_cyc[i] != log_cyc[i-2] + 3) begin failures++; $display("FAIL rr_pkt_period[%0d]: got %0d expected %0d", i, log_cyc[i], log_cyc[i-2] + 3); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int c_in;
    repeat (3) step();
    clear_logs();
    c_in = in_cnt[0];
    load(0, 1, 6, 32'h1000);
    i_rdy = 1'b0;
    drive_inputs();
    step();
    checks++; if (s_ordy !== 4'b0000 || s_ovld !== 1'b0) begin failures++; $display("FAIL bp_bubble: got ordy %b ovld %b expected 0000/0", s_ordy, s_ovld); end
    step();
    checks++; if (s_ordy !== 4'b0001) begin failures++; $display("FAIL bp_grant_ordy: got %b expected 0001", s_ordy); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (s_ovld !== 1'b1) begin failures++; $display("FAIL bp_ovld[%0d]: got %b expected 1", i, s_ovld); end
      checks++; if (s_odata !== 32'h1000 || s_olast !== 1'b0 || s_oid !== 2'd0) begin failures++; $display("FAIL bp_hold[%0d]: got %h/%b/%0d expected 1000/0/0", i, s_odata, s_olast, s_oid); end
      checks++; if (s_ordy !== 4'b0000) begin failures++; $display("FAIL bp_ordy[%0d]: got %b expected 0000", i, s_ordy); end
    end
    checks++; if (in_cnt[0] - c_in != 1) begin failures++; $display("FAIL bp_accepted: got %0d expected 1", in_cnt[0] - c_in); end
    i_rdy = 1'b1;
    for (int t = 0; t < 30 && log_data.size() < 6; t++) step();
    repeat (3) step();
    checks++;
    if (log_data.size() != 6) begin
      failures++; $display("FAIL bp_count: got %0d beats expected 6", log_data.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++; if (log_data[i] !== 32'h1000 + 32'(i) || log_last[i] !== (i == 5) || log_id[i] !== 2'd0) begin
          failures++; $display("FAIL bp_beat[%0d]: got %h/%b/%0d expected %h/%b/0", i, log_data[i], log_last[i], log_id[i], 32'h1000 + 32'(i), i == 5);
        end
      end
    end
  endtask

  task automatic test_vld_drop();
    int c1;
    logic [WIDTH-1:0] exp_d[5];
    clear_logs();
    exp_d = '{32'h2000, 32'h2001, 32'h2002, 32'h2003, 32'h3000};
    c1 = in_cnt[1];
    load(1, 1, 4, 32'h2000);
    load(0, 1, 1, 32'h3000);
    drive_inputs();
    for (int t = 0; t < 20 && in_cnt[1] - c1 < 2; t++) step();
    checks++; if (in_cnt[1] - c1 != 2) begin failures++; $display("FAIL drop_start: got %0d beats expected 2", in_cnt[1] - c1); end
    pause[1] = 1;
    drive_inputs();
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (s_ordy !== 4'b0010) begin failures++; $display("FAIL drop_ordy[%0d]: got %b expected 0010", i, s_ordy); end
    end
    pause[1] = 0;
    drive_inputs();
    for (int t = 0; t < 30 && log_data.size() < 5; t++) step();
    checks++;
    if (log_data.size() < 5) begin
      failures++; $display("FAIL drop_timeout: got %0d beats expected 5", log_data.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (log_data[i] !== exp_d[i] || log_id[i] !== ((i < 4) ? 2'd1 : 2'd0) || log_last[i] !== (i >= 3)) begin
          failures++; $display("FAIL drop_beat[%0d]: got %h/%0d/%b expected %h/%0d/%b", i, log_data[i], log_id[i], log_last[i], exp_d[i], (i < 4) ? 1 : 0, i >= 3);
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    repeat (3) step();
    load(2, 1, 4, 32'h4000);
    drive_inputs();
    for (int t = 0; t < 20 && s_ovld !== 1'b1; t++) step();
    checks++; if (s_ovld !== 1'b1) begin failures++; $display("FAIL rstm_locked: got ovld %b expected 1", s_ovld); end
    rst = 1'b1;
    for (int k = 0; k < N; k++) load(k, 0, 1, '0);
    drive_inputs();
    step();
    checks++; if (s_ordy !== 4'b0000) begin failures++; $display("FAIL rstm_ordy: got %b expected 0000", s_ordy); end
    rst = 1'b0;
    step();
    checks++; if (s_ovld !== 1'b0) begin failures++; $display("FAIL rstm_ovld: got %b expected 0", s_ovld); end
    checks++; if (s_odata !== 32'h0 || s_olast !== 1'b0 || s_oid !== 2'd0) begin failures++; $display("FAIL rstm_outs: got %h/%b/%0d expected 0/0/0", s_odata, s_olast, s_oid); end
    checks++; if (s_ordy !== 4'b0000) begin failures++; $display("FAIL rstm_idle_ordy: got %b expected 0000", s_ordy); end
    clear_logs();
    load(3, 1, 1, 32'h5000);
    load(0, 1, 1, 32'h6000);
    drive_inputs();
    for (int t = 0; t < 20 && log_data.size() < 2; t++) step();
    checks++;
    if (log_data.size() < 2) begin
      failures++; $display("FAIL rstm_timeout: got %0d beats expected 2", log_data.size());
    end else begin
      checks++; if (log_id[0] !== 2'd0 || log_id[1] !== 2'd3) begin failures++; $display("FAIL rstm_order: got %0d,%0d expected 0,3", log_id[0], log_id[1]); end
      checks++; if (log_data[0] !== 32'h6000 || log_data[1] !== 32'h5000) begin failures++; $display("FAIL rstm_data: got %h,%h expected 6000,5000", log_data[0], log_data[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_backpressure();
    test_vld_drop();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
